// File: rtl/motion_input_ctrl.sv
// motion_input_ctrl: turns four raw push-buttons into the one-cycle
// rotate/move step codes consumed by object_host.
//   clk, rst (async, active-low)      clock and reset
//   btn_left/right/fwd/back           raw asynchronous buttons, active-high
//   commit                            1 = downstream may take a step this cycle
//   rotate[1:0]                       01 right, 10 left, 00 none (registered)
//   move[1:0]                         10 forward, 01 backward, 00 none (registered)
//   pending[1:0]                      {rot_pending, move_pending}
// Each button is synchronised and debounced; opposing buttons cancel; a held
// direction auto-repeats; steps wait in a one-deep slot per axis until commit.
module motion_input_ctrl #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fwd,
  input  logic       btn_back,
  input  logic       commit,
  output logic [1:0] rotate,
  output logic [1:0] move,
  output logic [1:0] pending
);

  // The debounce counter starts at zero on the first mismatching edge, so the
  // level flips on the (DB_CYCLES+1)-th one: DB_CYCLES+2 edges after the raw
  // change is first sampled, once the two synchroniser edges are included.
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_FWD   = 2;
  localparam int B_BACK  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DELAY  = 2'b01,
    ST_REPEAT = 2'b10
  } axis_state_t;

  logic [3:0]            raw_s;
  logic [3:0]            sync1_r;
  logic [3:0]            sync2_r;
  logic [3:0]            deb_r;
  logic [3:0][CNT_W-1:0] db_cnt_r;

  // Axis index 0 = rotate, 1 = move; direction values are the output codes.
  logic [1:0][1:0]       req_s;
  axis_state_t [1:0]     state_r;
  axis_state_t [1:0]     state_s;
  logic [1:0][1:0]       dir_r;
  logic [1:0][1:0]       dir_s;
  logic [1:0][CNT_W-1:0] rep_cnt_r;
  logic [1:0][CNT_W-1:0] rep_cnt_s;
  logic [1:0]            step_s;
  logic [1:0][1:0]       step_dir_s;
  logic [1:0]            pend_r;
  logic [1:0][1:0]       pend_dir_r;
  logic [1:0][1:0]       out_r;

  assign raw_s = {btn_back, btn_fwd, btn_right, btn_left};

  // Two-flop synchroniser for every button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: the level follows the synced input only after a long enough mismatch run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_r <= 4'b0000;
      for (int i = 0; i < 4; i++) db_cnt_r[i] <= CNT_ZERO;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          db_cnt_r[i] <= CNT_ZERO;
        end else if (db_cnt_r[i] == DB_LAST) begin
          deb_r[i]    <= sync2_r[i];
          db_cnt_r[i] <= CNT_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Axis resolve: opposing buttons held together cancel to no request.
  always_comb begin
    req_s = 4'b0000;
    if (deb_r[B_RIGHT] && !deb_r[B_LEFT]) begin
      req_s[0] = 2'b01;
    end else if (deb_r[B_LEFT] && !deb_r[B_RIGHT]) begin
      req_s[0] = 2'b10;
    end else begin
      req_s[0] = 2'b00;
    end
    if (deb_r[B_FWD] && !deb_r[B_BACK]) begin
      req_s[1] = 2'b10;
    end else if (deb_r[B_BACK] && !deb_r[B_FWD]) begin
      req_s[1] = 2'b01;
    end else begin
      req_s[1] = 2'b00;
    end
  end

  // Axis FSM state register, held direction and repeat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < 2; a++) begin
        state_r[a]   <= ST_IDLE;
        dir_r[a]     <= 2'b00;
        rep_cnt_r[a] <= CNT_ZERO;
      end
    end else begin
      state_r   <= state_s;
      dir_r     <= dir_s;
      rep_cnt_r <= rep_cnt_s;
    end
  end

  // Axis FSM next state: any change of request while held returns to IDLE.
  always_comb begin
    state_s = state_r;
    for (int a = 0; a < 2; a++) begin
      case (state_r[a])
        ST_IDLE: begin
          if (req_s[a] != 2'b00) state_s[a] = ST_DELAY;
          else                   state_s[a] = ST_IDLE;
        end
        ST_DELAY: begin
          if (req_s[a] != dir_r[a])            state_s[a] = ST_IDLE;
          else if (rep_cnt_r[a] == DELAY_LAST) state_s[a] = ST_REPEAT;
          else                                 state_s[a] = ST_DELAY;
        end
        ST_REPEAT: begin
          if (req_s[a] != dir_r[a]) state_s[a] = ST_IDLE;
          else                      state_s[a] = ST_REPEAT;
        end
        default: state_s[a] = ST_IDLE;
      endcase
    end
  end

  // Axis FSM outputs: step strobe, its direction, and counter/direction updates.
  always_comb begin
    step_s     = 2'b00;
    step_dir_s = 4'b0000;
    dir_s      = dir_r;
    rep_cnt_s  = rep_cnt_r;
    for (int a = 0; a < 2; a++) begin
      case (state_r[a])
        ST_IDLE: begin
          if (req_s[a] != 2'b00) begin
            step_s[a]     = 1'b1;
            step_dir_s[a] = req_s[a];
            dir_s[a]      = req_s[a];
            rep_cnt_s[a]  = CNT_ZERO;
          end else begin
            step_s[a]     = 1'b0;
          end
        end
        ST_DELAY: begin
          if (req_s[a] != dir_r[a]) begin
            rep_cnt_s[a]  = CNT_ZERO;
          end else if (rep_cnt_r[a] == DELAY_LAST) begin
            step_s[a]     = 1'b1;
            step_dir_s[a] = dir_r[a];
            rep_cnt_s[a]  = CNT_ZERO;
          end else begin
            rep_cnt_s[a]  = rep_cnt_r[a] + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (req_s[a] != dir_r[a]) begin
            rep_cnt_s[a]  = CNT_ZERO;
          end else if (rep_cnt_r[a] == PERIOD_LAST) begin
            step_s[a]     = 1'b1;
            step_dir_s[a] = dir_r[a];
            rep_cnt_s[a]  = CNT_ZERO;
          end else begin
            rep_cnt_s[a]  = rep_cnt_r[a] + CNT_ONE;
          end
        end
        default: begin
          rep_cnt_s[a] = CNT_ZERO;
        end
      endcase
    end
  end

  // Pending slot and registered output: a step meeting a full, unconsumed slot
  // is dropped; on a consume edge the slot refills with the same-edge step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r     <= 2'b00;
      pend_dir_r <= 4'b0000;
      out_r      <= 4'b0000;
    end else begin
      for (int a = 0; a < 2; a++) begin
        if (pend_r[a] && commit) begin
          out_r[a]  <= pend_dir_r[a];
          pend_r[a] <= step_s[a];
          if (step_s[a]) pend_dir_r[a] <= step_dir_s[a];
        end else begin
          out_r[a] <= 2'b00;
          if (step_s[a] && !pend_r[a]) begin
            pend_r[a]     <= 1'b1;
            pend_dir_r[a] <= step_dir_s[a];
          end
        end
      end
    end
  end

  assign rotate  = out_r[0];
  assign move    = out_r[1];
  assign pending = {pend_r[0], pend_r[1]};

endmodule

// File: tb/tb_motion_input_ctrl.sv
// Bench for motion_input_ctrl with small timing parameters
// (debounce 4, first repeat 16, repeat period 8).
module tb_motion_input_ctrl;

  localparam int DB  = 4;
  localparam int DLY = 16;
  localparam int PER = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_fwd = 1'b0;
  logic       btn_back = 1'b0;
  logic       commit = 1'b1;
  logic [1:0] rotate;
  logic [1:0] move;
  logic [1:0] pending;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  motion_input_ctrl #(
    .DB_CYCLES(DB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(25)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_fwd(btn_fwd), .btn_back(btn_back),
    .commit(commit),
    .rotate(rotate), .move(move), .pending(pending)
  );

  // ---------------- behavioural model ----------------
  // Buttons: 0 left, 1 right, 2 fwd, 3 back. Axis 0 rotate, 1 move.
  logic [3:0] m_s1 = 4'b0000;
  logic [3:0] m_s2 = 4'b0000;
  logic [3:0] m_deb = 4'b0000;
  int         m_run [4];
  bit         m_act [2];
  logic [1:0] m_dir [2];
  int         m_age [2];
  bit         m_pend [2];
  logic [1:0] m_pdir [2];
  logic [1:0] m_out [2];

  task automatic model_clear();
    m_s1 = 4'b0000; m_s2 = 4'b0000; m_deb = 4'b0000;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    for (int a = 0; a < 2; a++) begin
      m_act[a] = 1'b0; m_dir[a] = 2'b00; m_age[a] = 0;
      m_pend[a] = 1'b0; m_pdir[a] = 2'b00; m_out[a] = 2'b00;
    end
  endtask

  task automatic model_edge();
    logic [1:0] req [2];
    bit         stp [2];
    logic [1:0] sdir [2];
    req[0] = (m_deb[1] && !m_deb[0]) ? 2'b01 : (m_deb[0] && !m_deb[1]) ? 2'b10 : 2'b00;
    req[1] = (m_deb[2] && !m_deb[3]) ? 2'b10 : (m_deb[3] && !m_deb[2]) ? 2'b01 : 2'b00;
    for (int a = 0; a < 2; a++) begin
      stp[a] = 1'b0; sdir[a] = 2'b00;
      if (!m_act[a]) begin
        if (req[a] != 2'b00) begin
          stp[a] = 1'b1; sdir[a] = req[a];
          m_act[a] = 1'b1; m_dir[a] = req[a]; m_age[a] = 0;
        end
      end else if (req[a] != m_dir[a]) begin
        m_act[a] = 1'b0;
      end else begin
        m_age[a]++;
        if (m_age[a] == DLY || (m_age[a] > DLY && (m_age[a] - DLY) % PER == 0)) begin
          stp[a] = 1'b1; sdir[a] = m_dir[a];
        end
      end
      if (m_pend[a] && commit) begin
        m_out[a] = m_pdir[a];
        m_pend[a] = stp[a];
        if (stp[a]) m_pdir[a] = sdir[a];
      end else begin
        m_out[a] = 2'b00;
        if (stp[a] && !m_pend[a]) begin
          m_pend[a] = 1'b1; m_pdir[a] = sdir[a];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DB + 1) begin
          m_deb[i] = m_s2[i]; m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {btn_back, btn_fwd, btn_right, btn_left};
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_clear();
      else      model_edge();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_rotate", rotate, m_out[0]);
      check("cyc_move", move, m_out[1]);
      check("cyc_pending", pending, {m_pend[0], m_pend[1]});
    end
  end

  // Hits are encoded as edge*4 + code, edge counted from the first edge of the window.
  int hits_rot [$];
  int hits_mov [$];
  int exp_q [$];

  task automatic watch(input int n);
    hits_rot.delete();
    hits_mov.delete();
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (rotate != 2'b00) hits_rot.push_back(k * 4 + int'(rotate));
      if (move != 2'b00)   hits_mov.push_back(k * 4 + int'(move));
    end
  endtask

  task automatic check_q(input string name, input int which);
    int    got [$];
    bit    same;
    string gs;
    string es;
    got = (which == 0) ? hits_rot : hits_mov;
    same = (got.size() == exp_q.size());
    gs = ""; es = "";
    foreach (got[i]) begin
      gs = {gs, $sformatf("%0d ", got[i])};
      if (same && got[i] != exp_q[i]) same = 1'b0;
    end
    foreach (exp_q[i]) es = {es, $sformatf("%0d ", exp_q[i])};
    checks++;
    if (same) passes++;
    else $display("FAIL %s: got {%s} expected {%s}", name, gs, es);
  endtask

  int glitch_bad;

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rotate", rotate, 2'b00);
    check("reset_move", move, 2'b00);
    check("reset_pending", pending, 2'b00);
    rst = 1'b1;
    watch(4);

    // 1: hold right: pulses after edges 8, 24, 32, 40
    btn_right = 1'b1;
    watch(41);
    exp_q.delete(); exp_q.push_back(8*4+1); exp_q.push_back(24*4+1);
    exp_q.push_back(32*4+1); exp_q.push_back(40*4+1);
    check_q("t1_rotate_pulses", 0);
    check("t1_move_quiet", hits_mov.size(), 0);
    btn_right = 1'b0;
    watch(30);

    // 2: 3-cycle fwd glitch never propagates
    glitch_bad = 0;
    btn_fwd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 2) btn_fwd = 1'b0;
      if (move != 2'b00 || pending != 2'b00) glitch_bad++;
    end
    check("t2_glitch_blocked", glitch_bad, 0);

    // 3: left+right cancel, releasing right yields one left pulse
    btn_left = 1'b1; btn_right = 1'b1;
    watch(30);
    check("t3_both_quiet", hits_rot.size(), 0);
    btn_right = 1'b0;
    watch(13);
    exp_q.delete(); exp_q.push_back(8*4+2);
    check_q("t3_left_pulse", 0);
    btn_left = 1'b0;
    watch(30);

    // 4: commit low holds one step; released the cycle after commit rises
    commit = 1'b0; btn_back = 1'b1;
    watch(40);
    check("t4_held_quiet", hits_mov.size(), 0);
    btn_back = 1'b0;
    watch(20);
    check("t4_release_quiet", hits_mov.size(), 0);
    check("t4_pending_set", pending, 2'b01);
    commit = 1'b1;
    watch(3);
    exp_q.delete(); exp_q.push_back(0*4+1);
    check_q("t4_commit_pulse", 1);
    check("t4_pending_clear", pending, 2'b00);
    watch(10);

    // 5: reset in the middle of a repeating hold
    btn_fwd = 1'b1;
    watch(28);
    exp_q.delete(); exp_q.push_back(8*4+2); exp_q.push_back(24*4+2);
    check_q("t5_pre_reset", 1);
    rst = 1'b0;
    #1;
    check("t5_rst_rotate", rotate, 2'b00);
    check("t5_rst_move", move, 2'b00);
    check("t5_rst_pending", pending, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    watch(12);
    exp_q.delete(); exp_q.push_back(8*4+2);
    check_q("t5_post_reset", 1);
    btn_fwd = 1'b0;
    watch(30);

    // 6: both axes at once
    btn_right = 1'b1; btn_back = 1'b1;
    watch(26);
    exp_q.delete(); exp_q.push_back(8*4+1); exp_q.push_back(24*4+1);
    check_q("t6_rotate", 0);
    check_q("t6_move", 1);
    btn_right = 1'b0; btn_back = 1'b0;
    watch(30);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
